rate_sequencer: RTL and testbench
=================================

// Module: rate_sequencer
// PURPOSE
// - Run-time controller for the divide-by-N timebase that drives the gray counter project.
// - Owns the divider count register and sequences start, stop and finite bursts.
// - Reconfigures the division ratio through a valid/ready handshake, applied glitch-free at a period boundary.
// - Outputs a 1-cycle tick (clock enable for downstream counters) and a 50% phase square wave.
// PARAMETERS
// - CNT_W     32       width of count register and cfg_half_i
// - DEF_HALF  2500000  half-period in clk_i cycles after reset (10 MHz / 4)
// - BURST_W   8        width of burst length
// PORTS
// - clk_i        in   1        single system clock; all logic on posedge
// - rst_i        in   1        asynchronous, active-high reset
// - start_i      in   1        1-cycle request to start in the mode given by mode_i
// - stop_i       in   1        1-cycle request to abort and return to IDLE
// - mode_i       in   1        0 = continuous, 1 = burst; sampled with start_i
// - burst_len_i  in   BURST_W  number of ticks in a burst; sampled with start_i
// - cfg_valid_i  in   1        new half-period offered
// - cfg_half_i   in   CNT_W    offered half-period in cycles; 0 is treated as 1
// - cfg_ready_o  out  1        block can accept a config (transfer = valid & ready)
// - tick_o       out  1        1-cycle pulse at every half-period end
// - phase_o      out  1        square wave; toggles with every tick_o
// - busy_o       out  1        high in RUN or BURST
// - done_o       out  1        1-cycle pulse when a burst completes
// - half_o       out  CNT_W    half-period currently in effect
// BEHAVIOUR
// - Reset values:
//   - state = IDLE, cnt = 0, half_r = DEF_HALF, pend_v = 0.
//   - tick_o = phase_o = busy_o = done_o = 0; cfg_ready_o = 1; half_o = DEF_HALF.
// - FSM states: IDLE, RUN, BURST, DONE.
//   - IDLE -> RUN: start_i & !mode_i.
//   - IDLE -> BURST: start_i & mode_i & burst_len_i != 0.
//   - IDLE -> DONE: start_i & mode_i & burst_len_i == 0. No ticks are produced.
//   - BURST -> DONE: on the tick that makes the tick count equal the latched length.
//   - DONE -> IDLE: always, after 1 cycle. done_o = 1 only in DONE.
//   - RUN/BURST -> IDLE: stop_i. cnt, phase_o and the tick count clear on the same edge; no tick in that cycle.
// - Priority and ignored requests:
//   - stop_i beats start_i when both are asserted.
//   - start_i is ignored outside IDLE.
//   - stop_i is ignored in IDLE and DONE.
// - Counting and timing:
//   - cnt counts 0..half_r-1 in RUN/BURST.
//   - At half_r-1: cnt <= 0, phase_o toggles, tick_o is registered high for 1 cycle.
//   - Start latency: start sampled at edge k gives cnt = 0 after edge k; tick_o is high after edge k+half_r.
//   - half_r = 1: tick_o is high every cycle and phase_o toggles every cycle.
// - Config handshake:
//   - cfg_ready_o = !pend_v.
//   - In IDLE/DONE, an accepted value loads half_r on the next edge.
//   - In RUN/BURST, the accepted value is held in pend (pend_v = 1).
//   - pend is copied to half_r on the terminal-count edge; pend_v clears there.
//   - The period in progress always completes with the old ratio.
//   - Accept and terminal count on the same edge: the value goes to pend and applies at the next boundary.
//   - stop_i with pend_v = 1: pend is applied immediately on entry to IDLE.
//   - A value of 0 is stored as 1. All compares are unsigned, CNT_W wide; cnt never exceeds half_r-1.
// - Async reset mid-operation aborts everything, drops pend, and returns to the reset values above.
// STRUCTURE
// - Include file rate_seq_defs.vh:
//   - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_BURST=2'd2, S_DONE=2'd3.
//   - MODE_CONT / MODE_BURST.
// - Sub-module div_core:
//   - terminal-count counter with clear and enable.
//   - half-period input; tc_o and phase_o outputs.
// - rate_sequencer contains the FSM, burst counter and config/pend registers.
// TESTING
// - Reset, no cfg, start mode 0: first tick 2500000 cycles after start; phase_o toggles each tick; half_o = 2500000.
// - cfg 4 in IDLE, start burst 3: ticks at +4, +8, +12 cycles; done_o at +13; busy_o drops at +13.
// - RUN, half 4, cfg 2 at cnt = 1: next tick still 4 cycles after the previous; then ticks every 2 cycles; cfg_ready_o low until applied.
// - Burst len 0: done_o 1 cycle after start; no tick_o; busy_o stays 0.
// - stop_i and start_i in the same cycle in RUN: IDLE, phase_o = 0, no tick; a later start restarts with cnt = 0.
// - rst_i asserted mid-BURST with pend_v = 1: all outputs at reset values; half_o = DEF_HALF; cfg_ready_o = 1.

Source files
------------

// File: rtl/rate_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rate_sequencer_pkg                                              |
// | Purpose  : Shared encodings for the rate sequencer: FSM state codes and    |
// |            the start-mode selector values.                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package rate_sequencer_pkg;

  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_BURST = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rate_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rate_sequencer_if                                               |
// | Purpose  : Configuration handshake bundle for the rate sequencer.          |
// |            cfg_valid_i / cfg_half_i offer a new half-period, cfg_ready_o   |
// |            grants it (transfer = valid & ready).                           |
// | Ports    : master - config producer, slave - rate_sequencer.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface rate_sequencer_if #(
  parameter int CNT_W = 32
) ();

  logic             cfg_valid_i;
  logic [CNT_W-1:0] cfg_half_i;
  logic             cfg_ready_o;

  modport master (
    output cfg_valid_i,
    output cfg_half_i,
    input  cfg_ready_o
  );

  modport slave (
    input  cfg_valid_i,
    input  cfg_half_i,
    output cfg_ready_o
  );

endinterface
`default_nettype wire

// File: rtl/rate_sequencer_div_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : div_core                                                        |
// | Purpose  : Terminal-count divider. Counts 0..half_i-1 while enabled,       |
// |            flags the last count on tc_o and toggles phase_o there.         |
// | Ports    : clk_i, rst_i (async, active-high), clr_i (clears count and      |
// |            phase), en_i (count enable), half_i (period length, >= 1),      |
// |            tc_o (combinational terminal count), phase_o (square wave).     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module div_core
  import rate_sequencer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] half_i,
  output logic             tc_o,
  output logic             phase_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;
  logic             w_tc;

  assign w_tc    = en_i && (r_cnt == (half_i - CNT_W'(1)));
  assign tc_o    = w_tc;
  assign phase_o = r_phase;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (clr_i) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_tc) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else if (en_i) begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end else begin
      // Parked at zero so a start always begins a fresh period.
      r_cnt   <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rate_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rate_sequencer                                                  |
// | Purpose  : Run-time controller for the divide-by-N timebase. Sequences     |
// |            continuous runs and finite bursts, produces a 1-cycle tick and  |
// |            a 50% square wave, and swaps the half-period glitch-free at a   |
// |            period boundary via a valid/ready handshake.                    |
// | Ports    : clk_i, rst_i (async, active-high), start_i, stop_i, mode_i,     |
// |            burst_len_i, cfg (slave: cfg_valid_i, cfg_half_i, cfg_ready_o), |
// |            tick_o, phase_o, busy_o, done_o, half_o.                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rate_sequencer
  import rate_sequencer_pkg::*;
#(
  parameter int          CNT_W    = 32,
  parameter int unsigned DEF_HALF = 2500000,
  parameter int          BURST_W  = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               mode_i,
  input  logic [BURST_W-1:0] burst_len_i,
  rate_sequencer_if.slave    cfg,
  output logic               tick_o,
  output logic               phase_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   half_o
);

  function automatic logic [CNT_W-1:0] half_sat(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  state_t             r_state;
  logic               r_tick;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_half;
  logic [CNT_W-1:0]   r_pend;
  logic               r_pend_v;
  logic [BURST_W-1:0] r_bcnt;
  logic [BURST_W-1:0] r_blen;

  logic               w_running;
  logic               w_stop;
  logic               w_bfin;
  logic               w_en;
  logic               w_tc;
  logic               w_cfg_acc;
  logic [CNT_W-1:0]   w_cfg_val;
  logic [BURST_W-1:0] w_bcnt_nxt;

  assign w_running  = (r_state == S_RUN) || (r_state == S_BURST);
  assign w_stop     = w_running && stop_i;
  assign w_bcnt_nxt = r_bcnt + BURST_W'(1);
  // The burst ends on the edge that sees its last tick pulse; stop outranks it.
  assign w_bfin     = (r_state == S_BURST) && r_tick && !stop_i && (w_bcnt_nxt == r_blen);
  // Counting halts on the leaving edge so no tick is issued there.
  assign w_en       = w_running && !stop_i && !w_bfin;
  assign w_cfg_acc  = cfg.cfg_valid_i && !r_pend_v;
  assign w_cfg_val  = half_sat(cfg.cfg_half_i);

  div_core #(
    .CNT_W (CNT_W)
  ) u_div_core (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (w_stop),
    .en_i    (w_en),
    .half_i  (r_half),
    .tc_o    (w_tc),
    .phase_o (phase_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_tick  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcnt  <= '0;
      r_blen  <= '0;
    end else begin
      r_tick <= w_tc;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_bcnt <= '0;
            r_blen <= burst_len_i;
            case (mode_i)
              MODE_CONT: begin
                r_state <= S_RUN;
                r_busy  <= 1'b1;
              end
              MODE_BURST: begin
                if (burst_len_i == '0) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= S_BURST;
                  r_busy  <= 1'b1;
                end
              end
            endcase
          end
        end
        S_RUN: begin
          if (stop_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_BURST: begin
          if (stop_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_bcnt  <= '0;
          end else if (r_tick) begin
            r_bcnt <= w_bcnt_nxt;
            if (w_bfin) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Config path: direct load while stopped, otherwise staged in pend and
  // swapped in on a terminal count so the running period keeps its ratio.
  // Leaving the running states flushes a staged value straight into half.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_half   <= CNT_W'(DEF_HALF);
      r_pend   <= '0;
      r_pend_v <= 1'b0;
    end else if (!w_running || w_stop || w_bfin) begin
      if (w_cfg_acc) begin
        r_half <= w_cfg_val;
      end else if (r_pend_v) begin
        r_half   <= r_pend;
        r_pend_v <= 1'b0;
      end
    end else if (w_tc && r_pend_v) begin
      r_half   <= r_pend;
      r_pend_v <= 1'b0;
    end else if (w_cfg_acc) begin
      r_pend   <= w_cfg_val;
      r_pend_v <= 1'b1;
    end
  end

  assign cfg.cfg_ready_o = !r_pend_v;
  assign tick_o          = r_tick;
  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign half_o          = r_half;

endmodule
`default_nettype wire

// File: tb/tb_rate_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rate_sequencer                                               |
// | Purpose  : Self-checking bench for rate_sequencer. A countdown-based       |
// |            reference model predicts every output each cycle; directed      |
// |            scenarios add absolute timing checks, then random traffic runs. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_rate_sequencer;

  localparam int          CNT_W    = 32;
  localparam int          BURST_W  = 8;
  localparam int unsigned DEF_HALF = 25;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_BURST = 2;
  localparam int M_DONE  = 3;

  logic               clk_i       = 1'b0;
  logic               rst_i       = 1'b1;
  logic               start_i     = 1'b0;
  logic               stop_i      = 1'b0;
  logic               mode_i      = 1'b0;
  logic [BURST_W-1:0] burst_len_i = '0;
  logic               tick_o;
  logic               phase_o;
  logic               busy_o;
  logic               done_o;
  logic [CNT_W-1:0]   half_o;

  rate_sequencer_if #(.CNT_W(CNT_W)) cfg_if ();

  rate_sequencer #(
    .CNT_W    (CNT_W),
    .DEF_HALF (DEF_HALF),
    .BURST_W  (BURST_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .mode_i      (mode_i),
    .burst_len_i (burst_len_i),
    .cfg         (cfg_if),
    .tick_o      (tick_o),
    .phase_o     (phase_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .half_o      (half_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: mode of operation, cycles remaining in the current
  // period, ticks remaining in a burst, and the config staging slot.
  int          m_st;
  int          m_rem;
  int          m_left;
  logic [31:0] m_half;
  logic [31:0] m_pend;
  bit          m_pend_v;
  bit          m_phase;
  bit          m_tick;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st     = M_IDLE;
    m_rem    = 0;
    m_left   = 0;
    m_half   = DEF_HALF;
    m_pend   = '0;
    m_pend_v = 1'b0;
    m_phase  = 1'b0;
    m_tick   = 1'b0;
  endtask

  task automatic model_edge(input bit st, input bit sp, input bit md,
                            input logic [7:0] bl, input bit cv, input logic [31:0] ch);
    bit          acc;
    bit          tprev;
    logic [31:0] val;
    acc    = cv && !m_pend_v;
    val    = (ch == 0) ? 32'd1 : ch;
    tprev  = m_tick;
    m_tick = 1'b0;
    case (m_st)
      M_RUN, M_BURST: begin
        if (sp || (m_st == M_BURST && tprev && m_left == 1)) begin
          if (sp) begin
            m_phase = 1'b0;
            m_st    = M_IDLE;
          end else begin
            m_st = M_DONE;
          end
          if (acc) m_half = val;
          else if (m_pend_v) begin
            m_half   = m_pend;
            m_pend_v = 1'b0;
          end
        end else begin
          if (m_st == M_BURST && tprev) m_left--;
          m_rem--;
          if (m_rem == 0) begin
            m_tick  = 1'b1;
            m_phase = !m_phase;
            if (m_pend_v) begin
              m_half   = m_pend;
              m_pend_v = 1'b0;
            end else if (acc) begin
              m_pend   = val;
              m_pend_v = 1'b1;
            end
            m_rem = int'(m_half);
          end else if (acc) begin
            m_pend   = val;
            m_pend_v = 1'b1;
          end
        end
      end
      M_DONE: begin
        if (acc) m_half = val;
        m_st = M_IDLE;
      end
      default: begin
        if (acc) m_half = val;
        if (st) begin
          m_rem = int'(m_half);
          if (!md) m_st = M_RUN;
          else if (bl != 0) begin
            m_st   = M_BURST;
            m_left = int'(bl);
          end else m_st = M_DONE;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("tick_o",      tick_o, m_tick);
    check("phase_o",     phase_o, m_phase);
    check("busy_o",      busy_o, (m_st == M_RUN || m_st == M_BURST));
    check("done_o",      done_o, (m_st == M_DONE));
    check("half_o",      half_o, m_half);
    check("cfg_ready_o", cfg_if.cfg_ready_o, !m_pend_v);
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare.
  task automatic step(input bit st, input bit sp, input bit md,
                      input logic [7:0] bl, input bit cv, input logic [31:0] ch);
    start_i            = st;
    stop_i             = sp;
    mode_i             = md;
    burst_len_i        = bl;
    cfg_if.cfg_valid_i = cv;
    cfg_if.cfg_half_i  = ch;
    @(posedge clk_i);
    model_edge(st, sp, md, bl, cv, ch);
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset();
    start_i            = 1'b0;
    stop_i             = 1'b0;
    cfg_if.cfg_valid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  int q_ticks[$];
  int first_tick;
  int done_at;
  int drop_at;
  bit ph_at_first;
  int found;

  initial begin
    cfg_if.cfg_valid_i = 1'b0;
    cfg_if.cfg_half_i  = '0;
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    compare_all();

    // Default ratio: first tick DEF_HALF cycles after start.
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
    first_tick = -1;
    q_ticks.delete();
    for (int i = 1; i <= 55; i++) begin
      idle();
      if (tick_o) begin
        q_ticks.push_back(i);
        if (first_tick < 0) begin
          first_tick  = i;
          ph_at_first = phase_o;
        end
      end
    end
    check("def_first_tick", first_tick, DEF_HALF);
    check("def_second_tick", (q_ticks.size() > 1) ? q_ticks[1] : -1, 2 * DEF_HALF);
    check("def_phase_first", ph_at_first, 1);
    check("def_half", half_o, DEF_HALF);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 32'd0);

    // cfg 4 in IDLE, burst of 3.
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 32'd4);
    step(1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 32'd0);
    q_ticks.delete();
    done_at = -1;
    drop_at = -1;
    for (int i = 1; i <= 16; i++) begin
      idle();
      if (tick_o) q_ticks.push_back(i);
      if (done_o && done_at < 0) done_at = i;
      if (!busy_o && drop_at < 0) drop_at = i;
    end
    check("burst_nticks", q_ticks.size(), 3);
    for (int j = 0; j < 3; j++)
      check("burst_tick_at", (q_ticks.size() > j) ? q_ticks[j] : -1, 4 * (j + 1));
    check("burst_done_at", done_at, 13);
    check("burst_busy_drop", drop_at, 13);

    // RUN at half 4, new ratio 2 offered while cnt = 1.
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      idle();
      if (tick_o) found = 1;
    end
    check("run_tick_found", found, 1);
    idle();
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 32'd2);
    check("cfg_ready_low", cfg_if.cfg_ready_o, 0);
    q_ticks.delete();
    for (int i = 3; i <= 10; i++) begin
      idle();
      if (tick_o) q_ticks.push_back(i);
      if (i == 3) check("cfg_ready_still_low", cfg_if.cfg_ready_o, 0);
    end
    check("swap_nticks", q_ticks.size(), 4);
    for (int j = 0; j < 4; j++)
      check("swap_tick_at", (q_ticks.size() > j) ? q_ticks[j] : -1, 4 + 2 * j);
    check("swap_half", half_o, 2);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 32'd4);

    // Zero-length burst.
    step(1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 32'd0);
    check("zlen_done", done_o, 1);
    check("zlen_busy", busy_o, 0);
    found = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      if (tick_o || busy_o) found++;
    end
    check("zlen_quiet", found, 0);

    // stop and start together while running.
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
    repeat (5) idle();
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 32'd0);
    check("stopstart_busy", busy_o, 0);
    check("stopstart_phase", phase_o, 0);
    check("stopstart_tick", tick_o, 0);
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
    first_tick = -1;
    for (int i = 1; i <= 8; i++) begin
      idle();
      if (tick_o && first_tick < 0) first_tick = i;
    end
    check("restart_first_tick", first_tick, 4);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 32'd0);

    // Reset mid-burst with a staged config.
    step(1'b1, 1'b0, 1'b1, 8'd5, 1'b0, 32'd0);
    repeat (2) idle();
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 32'd7);
    check("pend_ready_low", cfg_if.cfg_ready_o, 0);
    async_reset();
    check("rst_half", half_o, DEF_HALF);
    check("rst_ready", cfg_if.cfg_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_tick", tick_o, 0);
    check("rst_phase", phase_o, 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end else begin
        step($urandom_range(0, 7) == 0,
             $urandom_range(0, 39) == 0,
             1'($urandom_range(0, 1)),
             8'($urandom_range(0, 4)),
             $urandom_range(0, 5) == 0,
             32'($urandom_range(0, 6)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
